// File: rtl/vga_timing_gen.sv
// vga_timing_gen: 640x480@60 VGA raster timing at Clk/2 pixel rate with registered syncs and frame counter
module vga_timing_gen #(
  parameter int H_VIS  = 640,
  parameter int H_FP   = 16,
  parameter int H_SYNC = 96,
  parameter int H_BP   = 48,
  parameter int V_VIS  = 480,
  parameter int V_FP   = 10,
  parameter int V_SYNC = 2,
  parameter int V_BP   = 33
) (
  input  logic        Clk,
  input  logic        Reset,
  output logic        pixel_clk,
  output logic        hs,
  output logic        vs,
  output logic        blank_n,
  output logic [9:0]  DrawX,
  output logic [9:0]  DrawY,
  output logic        frame_start,
  output logic [15:0] frame_count
);
  localparam logic [9:0] HL  = 10'(H_VIS + H_FP + H_SYNC + H_BP - 1);
  localparam logic [9:0] VL  = 10'(V_VIS + V_FP + V_SYNC + V_BP - 1);
  localparam logic [9:0] HS0 = 10'(H_VIS + H_FP);
  localparam logic [9:0] HS1 = 10'(H_VIS + H_FP + H_SYNC);
  localparam logic [9:0] VS0 = 10'(V_VIS + V_FP);
  localparam logic [9:0] VS1 = 10'(V_VIS + V_FP + V_SYNC);
  localparam logic [9:0] HV  = 10'(H_VIS);
  localparam logic [9:0] VV  = 10'(V_VIS);
  logic       ph, hwrap, fwrap;
  logic [9:0] nx, ny;
  assign pixel_clk = ph;
  always_comb begin
    hwrap = ph && DrawX == HL;
    fwrap = hwrap && DrawY == VL;
    nx    = ph ? (hwrap ? 10'd0 : DrawX + 10'd1) : DrawX;
    ny    = hwrap ? (fwrap ? 10'd0 : DrawY + 10'd1) : DrawY;
  end
  always_ff @(posedge Clk) begin
    if (Reset) begin
      ph          <= 1'b0;
      DrawX       <= '0;
      DrawY       <= '0;
      hs          <= 1'b1;
      vs          <= 1'b1;
      blank_n     <= 1'b1;
      frame_start <= 1'b0;
      frame_count <= '0;
    end else begin
      ph          <= ~ph;
      DrawX       <= nx;
      DrawY       <= ny;
      hs          <= !(nx >= HS0 && nx < HS1);
      vs          <= !(ny >= VS0 && ny < VS1);
      blank_n     <= nx < HV && ny < VV;
      frame_start <= fwrap;
      frame_count <= frame_count + {15'b0, fwrap};
    end
  end
endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen: randomized-reset scoreboard bench against a cycle-count raster model (full and shrunk timing)
module tb_vga_timing_gen;
  logic Clk = 1'b0, Reset = 1'b1;
  logic pc_f, hs_f, vs_f, bl_f, fs_f, pc_s, hs_s, vs_s, bl_s, fs_s;
  logic [9:0] x_f, y_f, x_s, y_s;
  logic [15:0] fc_f, fc_s;
  typedef struct packed {
    logic ph, hs, vs, bl, fs;
    logic [9:0] x, y;
    logic [15:0] fc;
  } exp_t;
  exp_t qf[$], qs[$];
  int t = 0, adj = 0, checks = 0, errors = 0;
  always #10 Clk = ~Clk;
  vga_timing_gen dut_f (.Clk(Clk), .Reset(Reset), .pixel_clk(pc_f), .hs(hs_f), .vs(vs_f),
    .blank_n(bl_f), .DrawX(x_f), .DrawY(y_f), .frame_start(fs_f), .frame_count(fc_f));
  vga_timing_gen #(.H_VIS(16), .H_FP(2), .H_SYNC(4), .H_BP(2), .V_VIS(8), .V_FP(2), .V_SYNC(2), .V_BP(2))
    dut_s (.Clk(Clk), .Reset(Reset), .pixel_clk(pc_s), .hs(hs_s), .vs(vs_s),
    .blank_n(bl_s), .DrawX(x_s), .DrawY(y_s), .frame_start(fs_s), .frame_count(fc_s));
  // Expected outputs t cycles after the last reset edge: each pixel is two cycles, raster is row-major
  function automatic exp_t model(bit s, int tc, int a);
    int hv = s ? 16 : 640, hf = s ? 2 : 16, hn = s ? 4 : 96, hb = s ? 2 : 48;
    int vv = s ? 8 : 480, vf = s ? 2 : 10, vn = 2, vb = s ? 2 : 33;
    int ht = hv + hf + hn + hb, vt = vv + vf + vn + vb;
    int pix = tc / 2, x = pix % ht, y = (pix / ht) % vt, fr = pix / (ht * vt);
    exp_t e;
    e.ph = (tc % 2) == 1;
    e.x  = 10'(x);
    e.y  = 10'(y);
    e.hs = !(x >= hv + hf && x < hv + hf + hn);
    e.vs = !(y >= vv + vf && y < vv + vf + vn);
    e.bl = x < hv && y < vv;
    e.fs = (tc % 2) == 0 && pix != 0 && pix % (ht * vt) == 0;
    e.fc = 16'(fr + a);
    return e;
  endfunction
  task automatic chk(string n, int a, int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0d)", n, a, e, t);
    end
  endtask
  task automatic step(bit rst, bit frc);
    @(negedge Clk);
    Reset = rst;
    if (frc) begin
      force dut_s.frame_count = 16'hFFFF;
      adj = 65535 - (t / 2) / 336;
    end
    t = rst ? 0 : t + 1;
    if (rst) adj = 0;
    qf.push_back(model(1'b0, t, 0));
    qs.push_back(model(1'b1, t, adj));
    if (frc) begin
      #1;
      release dut_s.frame_count;
    end
  endtask
  initial begin
    exp_t e;
    forever begin
      @(posedge Clk);
      #1;
      if (qf.size() > 0) begin
        e = qf.pop_front();
        chk("full_pixel_clk", pc_f, e.ph);
        chk("full_DrawX", x_f, e.x);
        chk("full_DrawY", y_f, e.y);
        chk("full_hs", hs_f, e.hs);
        chk("full_vs", vs_f, e.vs);
        chk("full_blank_n", bl_f, e.bl);
        chk("full_frame_start", fs_f, e.fs);
        chk("full_frame_count", fc_f, e.fc);
      end
      if (qs.size() > 0) begin
        e = qs.pop_front();
        chk("small_pixel_clk", pc_s, e.ph);
        chk("small_DrawX", x_s, e.x);
        chk("small_DrawY", y_s, e.y);
        chk("small_hs", hs_s, e.hs);
        chk("small_vs", vs_s, e.vs);
        chk("small_blank_n", bl_s, e.bl);
        chk("small_frame_start", fs_s, e.fs);
        chk("small_frame_count", fc_s, e.fc);
      end
    end
  end
  initial begin
    exp_t m;
    int n;
    repeat (3) step(1'b1, 1'b0);
    repeat (3000) step(1'b0, 1'b0);
    n = 0;
    m = model(1'b0, t, 0);
    while (!(m.x == 10'd300 && m.y == 10'd2 && m.ph == 1'b0) && n < 5000) begin
      step(1'b0, 1'b0);
      m = model(1'b0, t, 0);
      n++;
    end
    chk("reach_x300_y2", int'(n < 5000), 1);
    step(1'b1, 1'b0);
    repeat (20) begin
      repeat ($urandom_range(1, 1500)) step(1'b0, 1'b0);
      repeat ($urandom_range(1, 3)) step(1'b1, 1'b0);
    end
    repeat (200) step(1'b0, 1'b0);
    n = 0;
    while (((t / 2) % 336) != 100 && n < 1000) begin
      step(1'b0, 1'b0);
      n++;
    end
    step(1'b0, 1'b1);
    repeat (2000) step(1'b0, 1'b0);
    repeat (3) @(posedge Clk);
    #2;
    chk("scoreboard_drained", qf.size() + qs.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
